// File: rtl/lc3_pkg.sv
// Shared LC-3 fetch definitions: control-flow opcodes, fetch FSM states and
// the offset sign-extension helper.
package lc3_pkg;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_JSR = 4'b0100;
   localparam logic [3:0] OP_JMP = 4'b1100;
   localparam logic [3:0] OP_ST  = 4'b0011;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DROP
   } fetch_state_e;

   // Sign-extends the low 'bits' bits of an instruction offset field to 32 bits;
   // callers truncate the result to their address width.
   function automatic logic [31:0] sext(input logic [10:0] value, input int bits);
      logic [31:0] result;
      logic        sign;
      sign = 1'b0;
      for (int i = 0; i < 11; i++) begin
         if (i == bits - 1) sign = value[i];
      end
      result = {32{sign}};
      for (int i = 0; i < 11; i++) begin
         if (i < bits) result[i] = value[i];
      end
      return result;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, instr} pairs. Flush overrides push and
// pop; push and pop together are legal even when full.
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       data_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   empty_o,
   output logic                   full_o,
   output logic [WIDTH-1:0]       head_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FULL_CNT);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of statement order across always blocks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; only pointers and count are, and
   // the top masks head data while the queue is empty.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/fetch_queue.sv
// LC-3 fetch stage with a prefetch queue: one outstanding memory read at a time,
// {pc, instr} pairs buffered for decode, BR/JSR/JMP redirects resolved locally.
module fetch_queue
   import lc3_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter int                DATA_W   = 16,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_start,
   input  logic              redir_valid,
   input  logic [3:0]        opCode_in,
   input  logic [10:0]       offset_in,
   input  logic [ADDR_W-1:0] reg_in,
   input  logic [2:0]        br_nzp,
   input  logic [2:0]        result_nzp,
   input  logic [ADDR_W-1:0] redir_pc,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              instr_ready,
   output logic [ADDR_W-1:0] pc
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DEPTH - 1);

   fetch_state_e             state_q;
   logic [ADDR_W-1:0]        pc_q;
   logic [ADDR_W-1:0]        mem_addr_q;
   logic                     mem_req_q;

   logic                     redir_taken;
   logic [ADDR_W-1:0]        redir_target;
   logic [ADDR_W-1:0]        pc_inc;
   logic [ADDR_W-1:0]        next_addr;
   logic                     space;
   logic                     issue;

   logic                     fifo_push;
   logic                     fifo_empty;
   logic                     fifo_full;
   logic [CNT_W-1:0]         fifo_count;
   logic [ADDR_W+DATA_W-1:0] fifo_head;

   // NOTE: every always_comb output gets a default before any branch so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      redir_taken  = 1'b0;
      redir_target = redir_pc;
      if (redir_valid) begin
         case (opCode_in)
            OP_BR: begin
               redir_taken  = |(br_nzp & result_nzp);
               redir_target = redir_pc + ADDR_W'(sext(offset_in, 9));
            end
            OP_JSR: begin
               redir_taken  = 1'b1;
               redir_target = redir_pc + ADDR_W'(sext(offset_in, 11));
            end
            OP_JMP: begin
               redir_taken  = 1'b1;
               redir_target = reg_in;
            end
            default: begin
               redir_taken  = 1'b0;
               redir_target = redir_pc;
            end
         endcase
      end
   end

   // Space counts the in-flight request as already occupying a slot.
   assign space  = !fifo_full && !(mem_req_q && (fifo_count == LAST_SLOT));
   assign pc_inc = pc_q + ADDR_W'(1);

   // A taken redirect flushes the queue this edge, so space is guaranteed.
   assign issue     = fetch_start && (redir_taken || space);
   assign next_addr = redir_taken ? redir_target
                    : (state_q == REQ) ? pc_inc : pc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               pc_q <= next_addr;
               if (issue) begin
                  state_q    <= REQ;
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= next_addr;
               end
            end
            REQ: begin
               if (mem_ack) begin
                  pc_q <= next_addr;
                  if (issue) begin
                     mem_addr_q <= next_addr;
                  end else begin
                     state_q   <= IDLE;
                     mem_req_q <= 1'b0;
                  end
               end else if (redir_taken) begin
                  pc_q    <= redir_target;
                  state_q <= DROP;
               end
            end
            DROP: begin
               // Address and request stay on the abandoned read until it acks.
               pc_q <= next_addr;
               if (mem_ack) begin
                  if (issue) begin
                     state_q    <= REQ;
                     mem_addr_q <= next_addr;
                  end else begin
                     state_q   <= IDLE;
                     mem_req_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q   <= IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign fifo_push = (state_q == REQ) && mem_ack && !redir_taken;

   fetch_fifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .data_i  ({mem_addr_q, mem_rdata}),
      .pop_i   (instr_ready),
      .flush_i (redir_taken),
      .count_o (fifo_count),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .head_o  (fifo_head)
   );

   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign pc          = pc_q;
   assign instr_valid = !fifo_empty;
   assign instr       = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
   assign instr_pc    = fifo_empty ? '0 : fifo_head[ADDR_W+DATA_W-1:DATA_W];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, prefetch fill, BR/JMP/JSR redirects,
// redirect during an outstanding read, PC wrap and mid-request reset.
module tb_fetch_queue;
   import lc3_pkg::*;

   localparam int AW = 16;
   localparam int DW = 16;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          fetch_start, redir_valid, instr_ready;
   logic [3:0]    opCode_in;
   logic [10:0]   offset_in;
   logic [AW-1:0] reg_in, redir_pc;
   logic [2:0]    br_nzp, result_nzp;
   logic          mem_req, mem_ack, instr_valid;
   logic [AW-1:0] mem_addr, instr_pc, pc;
   logic [DW-1:0] mem_rdata, instr;

   logic          fetch_start2, instr_ready2;
   logic          mem_req2, mem_ack2, instr_valid2;
   logic [AW-1:0] mem_addr2, instr_pc2, pc2;
   logic [DW-1:0] mem_rdata2, instr2;

   int            checks = 0;
   int            errors = 0;

   fetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .redir_valid(redir_valid),
      .opCode_in(opCode_in), .offset_in(offset_in), .reg_in(reg_in), .br_nzp(br_nzp),
      .result_nzp(result_nzp), .redir_pc(redir_pc), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr(instr),
      .instr_pc(instr_pc), .instr_ready(instr_ready), .pc(pc)
   );

   fetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .RESET_PC(16'hFFFE)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start2), .redir_valid(1'b0),
      .opCode_in(4'b0011), .offset_in(11'h000), .reg_in(16'h0000), .br_nzp(3'b000),
      .result_nzp(3'b000), .redir_pc(16'h0000), .mem_req(mem_req2), .mem_addr(mem_addr2),
      .mem_ack(mem_ack2), .mem_rdata(mem_rdata2), .instr_valid(instr_valid2), .instr(instr2),
      .instr_pc(instr_pc2), .instr_ready(instr_ready2), .pc(pc2)
   );

   // Memory model for the main instance: acks after ack_delay waiting cycles.
   logic          mem_en;
   int            ack_delay;
   int            wait_cnt;
   logic [AW-1:0] req_log [$];

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_ack   = 1'b0;
         mem_rdata = '0;
         wait_cnt  = 0;
      end else begin
         mem_ack = 1'b0;
         if (mem_en && mem_req) begin
            if (wait_cnt >= ack_delay) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_addr ^ 16'hA5A5;
               req_log.push_back(mem_addr);
               wait_cnt  = 0;
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   // Memory model for the wrap instance: acks every request immediately.
   logic [AW-1:0] log2 [$];

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_ack2   = 1'b0;
         mem_rdata2 = '0;
      end else begin
         mem_ack2   = mem_req2;
         mem_rdata2 = mem_addr2 ^ 16'hA5A5;
         if (mem_req2) log2.push_back(mem_addr2);
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      opCode_in = OP_ST;
      fetch_start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 16'h0000); end
      checks++; if (instr !== 16'h0000 || instr_pc !== 16'h0000) begin errors++; $display("FAIL reset_head got %h/%h exp 0000/0000", instr_pc, instr); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mem_req); end
      checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h exp %h", mem_addr, 16'h0000); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc_rel got %h exp %h", pc, 16'h0000); end
   endtask

   task automatic test_fill();
      req_log.delete();
      mem_en = 1'b1;
      ack_delay = 0;
      instr_ready = 1'b0;
      fetch_start = 1'b1;
      @(posedge clk); #1;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin errors++; $display("FAIL fill_first_req got %b/%h exp 1/0000", mem_req, mem_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fill_valid_early got %b exp 0", instr_valid); end
      @(posedge clk); #1;
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL fill_ack_latency got %b exp 1", instr_valid); end
      checks++; if (mem_addr !== 16'h0001) begin errors++; $display("FAIL fill_second_addr got %h exp %h", mem_addr, 16'h0001); end
      repeat (12) @(posedge clk);
      #1;
      checks++; if (req_log.size() != 4) begin errors++; $display("FAIL fill_req_count got %0d exp 4", req_log.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (req_log[i] !== AW'(i)) begin errors++; $display("FAIL fill_req_addr[%0d] got %h exp %h", i, req_log[i], AW'(i)); end
      end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fill_full_req got %b exp 0", mem_req); end
      checks++; if (pc !== 16'h0004) begin errors++; $display("FAIL fill_pc got %h exp %h", pc, 16'h0004); end
      checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL fill_instr_pc got %h exp %h", instr_pc, 16'h0000); end
      checks++; if (instr !== 16'hA5A5) begin errors++; $display("FAIL fill_instr got %h exp %h", instr, 16'hA5A5); end
   endtask

   task automatic test_br();
      mem_en = 1'b0;
      opCode_in = OP_BR;
      br_nzp = 3'b010;
      result_nzp = 3'b010;
      redir_pc = 16'h0003;
      offset_in = 11'h1FE;
      redir_valid = 1'b1;
      @(posedge clk); #1;
      redir_valid = 1'b0;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL br_flush got %b exp 0", instr_valid); end
      checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL br_pc got %h exp %h", pc, 16'h0001); end
      checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0001) begin errors++; $display("FAIL br_req got %b/%h exp 1/0001", mem_req, mem_addr); end
      result_nzp = 3'b100;
      redir_valid = 1'b1;
      @(posedge clk); #1;
      redir_valid = 1'b0;
      checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL br_nt_pc got %h exp %h", pc, 16'h0001); end
      checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0001) begin errors++; $display("FAIL br_nt_req got %b/%h exp 1/0001", mem_req, mem_addr); end
   endtask

   task automatic test_drop();
      bit found;
      req_log.delete();
      ack_delay = 3;
      mem_en = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(posedge clk); #1;
         if (mem_req && mem_addr == 16'h0002) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL drop_wait_req2 got timeout exp request to 0002"); end
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0001 || instr !== 16'hA5A4) begin errors++; $display("FAIL drop_pre_head got %b/%h/%h exp 1/0001/a5a4", instr_valid, instr_pc, instr); end
      opCode_in = OP_JMP;
      reg_in = 16'h4000;
      redir_valid = 1'b1;
      @(posedge clk); #1;
      redir_valid = 1'b0;
      checks++; if (pc !== 16'h4000) begin errors++; $display("FAIL drop_pc got %h exp %h", pc, 16'h4000); end
      checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0002) begin errors++; $display("FAIL drop_hold got %b/%h exp 1/0002", mem_req, mem_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL drop_flush got %b exp 0", instr_valid); end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (mem_addr == 16'h4000) break;
         checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0002) begin errors++; $display("FAIL drop_stable got %b/%h exp 1/0002", mem_req, mem_addr); end
      end
      checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h4000) begin errors++; $display("FAIL drop_new_req got %b/%h exp 1/4000", mem_req, mem_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL drop_discard got %b exp 0", instr_valid); end
      checks++; if (req_log.size() != 2 || req_log[1] !== 16'h0002) begin errors++; $display("FAIL drop_acked got %0d entries exp 2 ending 0002", req_log.size()); end
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(posedge clk); #1;
         if (instr_valid) found = 1'b1;
      end
      checks++; if (!found || instr_pc !== 16'h4000 || instr !== 16'hE5A5) begin errors++; $display("FAIL drop_first_head got %b/%h/%h exp 1/4000/e5a5", found, instr_pc, instr); end
   endtask

   task automatic test_jsr();
      bit idle;
      fetch_start = 1'b0;
      idle = 1'b0;
      for (int i = 0; i < 20 && !idle; i++) begin
         @(posedge clk); #1;
         if (!mem_req) idle = 1'b1;
      end
      checks++; if (!idle) begin errors++; $display("FAIL jsr_wait_idle got timeout exp mem_req 0"); end
      opCode_in = OP_JSR;
      redir_pc = 16'h0100;
      offset_in = 11'h400;
      redir_valid = 1'b1;
      @(posedge clk); #1;
      redir_valid = 1'b0;
      checks++; if (pc !== 16'hFD00) begin errors++; $display("FAIL jsr_pc got %h exp %h", pc, 16'hFD00); end
      checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL jsr_flush got %b/%b exp 0/0", instr_valid, mem_req); end
      opCode_in = OP_ST;
      reg_in = 16'h1234;
      redir_valid = 1'b1;
      @(posedge clk); #1;
      redir_valid = 1'b0;
      checks++; if (pc !== 16'hFD00 || mem_req !== 1'b0) begin errors++; $display("FAIL st_no_effect got %h/%b exp fd00/0", pc, mem_req); end
   endtask

   task automatic test_wrap();
      logic [AW-1:0] exp_w [4];
      exp_w[0] = 16'hFFFE;
      exp_w[1] = 16'hFFFF;
      exp_w[2] = 16'h0000;
      exp_w[3] = 16'h0001;
      log2.delete();
      instr_ready2 = 1'b1;
      fetch_start2 = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      fetch_start2 = 1'b0;
      checks++; if (log2.size() < 4) begin errors++; $display("FAIL wrap_count got %0d exp >=4", log2.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (log2[i] !== exp_w[i]) begin errors++; $display("FAIL wrap_addr[%0d] got %h exp %h", i, log2[i], exp_w[i]); end
      end
   endtask

   task automatic test_reset_mid();
      bit found;
      req_log.delete();
      ack_delay = 1;
      instr_ready = 1'b0;
      fetch_start = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge clk); #1;
         if (req_log.size() == 3) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL rmid_wait got timeout exp 3 acks"); end
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'hFD00) begin errors++; $display("FAIL rmid_pre_head got %b/%h exp 1/fd00", instr_valid, instr_pc); end
      checks++; if (mem_req !== 1'b1 || mem_addr !== 16'hFD03) begin errors++; $display("FAIL rmid_pre_req got %b/%h exp 1/fd03", mem_req, mem_addr); end
      rst_n = 1'b0;
      #1;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", instr_valid); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmid_req got %b exp 0", mem_req); end
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL rmid_pc got %h exp %h", pc, 16'h0000); end
      checks++; if (pc2 !== 16'hFFFE) begin errors++; $display("FAIL rmid_pc2 got %h exp %h", pc2, 16'hFFFE); end
      fetch_start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (mem_req !== 1'b0 || pc !== 16'h0000) begin errors++; $display("FAIL rmid_release got %b/%h exp 0/0000", mem_req, pc); end
   endtask

   initial begin
      fetch_start  = 1'b0;
      redir_valid  = 1'b0;
      opCode_in    = OP_ST;
      offset_in    = '0;
      reg_in       = '0;
      redir_pc     = '0;
      br_nzp       = '0;
      result_nzp   = '0;
      instr_ready  = 1'b0;
      mem_en       = 1'b0;
      ack_delay    = 0;
      fetch_start2 = 1'b0;
      instr_ready2 = 1'b0;

      test_reset();
      test_fill();
      test_br();
      test_drop();
      test_jsr();
      test_wrap();
      test_reset_mid();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
